// File: rtl/srl_fifo_reader_if.sv
// Handshake bundle for srl_fifo_reader: write port, fall-through read port and occupancy.
// The FIFO takes the slave side; the producer/consumer environment takes the master side.
interface srl_fifo_reader_if #(
  parameter int width = 8,
  parameter int depth = 16
);
  localparam int CW = $clog2(depth + 1);

  logic [width-1:0] i;
  logic             i_valid;
  logic             i_ready;
  logic [width-1:0] q;
  logic             q_valid;
  logic             q_ready;
  logic [CW-1:0]    count;

  modport master (
    output i, i_valid, q_ready,
    input  i_ready, q, q_valid, count
  );

  modport slave (
    input  i, i_valid, q_ready,
    output i_ready, q, q_valid, count
  );
endinterface

// File: rtl/srl_fifo_reader.sv
// Shift-register FIFO. Pushes shift into an unreset chain, and the oldest entry is read
// through a tap that sits at count-1. The chain maps onto addressable SRL primitives.
module srl_fifo_reader #(
  parameter int width = 8,
  parameter int depth = 16
) (
  input logic               clk,
  input logic               rst,
  srl_fifo_reader_if.slave  bus
);
  localparam int CW = $clog2(depth + 1);
  localparam int AW = (depth > 1) ? $clog2(depth) : 1;
  localparam logic [CW-1:0] FULL = CW'(depth);

  logic [width-1:0] stor_q [depth];
  logic [CW-1:0]    count_q, count_d;
  logic             rst_q;
  logic [AW-1:0]    addr;
  logic             i_ready, q_valid, push, pop;

  // NOTE: the data chain is deliberately left without reset or init value. Any reset or
  // extra enable term would prevent it from mapping onto SRL cells.
  always_ff @(posedge clk) begin
    if (push) begin
      stor_q[0] <= bus.i;
      for (int k = 1; k < depth; k++) stor_q[k] <= stor_q[k-1];
    end
  end

  // The tap follows occupancy. When count is 0 the address wraps, but q is don't-care then.
  assign addr  = AW'(count_q - 1'b1);
  assign bus.q = stor_q[addr];

  // Both flags stay low through rst and the cycle after it. Neither flag looks at the
  // other side's handshake input.
  assign q_valid = (count_q != '0)   & ~rst_q & ~rst;
  assign i_ready = (count_q != FULL) & ~rst_q & ~rst;

  assign push = bus.i_valid & i_ready;
  assign pop  = q_valid & bus.q_ready;

  // NOTE: count_d gets a default before any branch, so no path leaves it unassigned and no
  // latch is inferred.
  always_comb begin
    count_d = count_q;
    if (rst)               count_d = '0;
    else if (push && !pop) count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  // NOTE: state registers use non-blocking assignments, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    rst_q   <= rst;
    count_q <= count_d;
  end

  assign bus.i_ready = i_ready;
  assign bus.q_valid = q_valid;
  assign bus.count   = count_q;
endmodule

// File: tb/tb_srl_fifo_reader.sv
// Directed bench for srl_fifo_reader (width 8, depth 16).
// Expected values are hand-derived, and outputs are sampled 2 ns after each rising edge.
module tb_srl_fifo_reader;
  localparam int W = 8;
  localparam int D = 16;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  srl_fifo_reader_if #(.width(W), .depth(D)) bus ();

  srl_fifo_reader #(.width(W), .depth(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.i = '0; bus.i_valid = 1'b0; bus.q_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.count); end
    checks++;
    if (bus.q_valid !== 1'b0) begin errors++; $display("FAIL reset_q_valid got %b want 0", bus.q_valid); end
    checks++;
    if (bus.i_ready !== 1'b0) begin errors++; $display("FAIL reset_i_ready got %b want 0", bus.i_ready); end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.i_ready !== 1'b0) begin errors++; $display("FAIL post_rst_i_ready got %b want 0", bus.i_ready); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (bus.count !== 5'd0 || bus.q_valid !== 1'b0 || bus.i_ready !== 1'b1) begin
        errors++;
        $display("FAIL idle_%0d got count=%0d q_valid=%b i_ready=%b want 0/0/1",
                 c, bus.count, bus.q_valid, bus.i_ready);
      end
    end
  endtask

  task automatic test_fill();
    bus.q_ready = 1'b0;
    for (int k = 1; k <= D; k++) begin
      bus.i = W'(k); bus.i_valid = 1'b1;
      tick();
      checks++;
      if (bus.count !== 5'(k)) begin errors++; $display("FAIL fill_count_%0d got %0d want %0d", k, bus.count, k); end
    end
    checks++;
    if (bus.i_ready !== 1'b0) begin errors++; $display("FAIL full_i_ready got %b want 0", bus.i_ready); end
    bus.i = 8'hAA; bus.i_valid = 1'b1;
    tick();
    bus.i_valid = 1'b0;
    checks++;
    if (bus.count !== 5'd16) begin errors++; $display("FAIL overflow_count got %0d want 16", bus.count); end
    checks++;
    if (bus.q_valid !== 1'b1 || bus.q !== 8'h01) begin
      errors++; $display("FAIL full_head got valid=%b q=%h want 1/01", bus.q_valid, bus.q);
    end
  endtask

  task automatic test_drain();
    bus.i_valid = 1'b0; bus.q_ready = 1'b1;
    for (int k = 1; k <= D; k++) begin
      checks++;
      if (bus.q_valid !== 1'b1 || bus.q !== W'(k)) begin
        errors++; $display("FAIL drain_q_%0d got valid=%b q=%h want 1/%h", k, bus.q_valid, bus.q, W'(k));
      end
      tick();
      checks++;
      if (bus.count !== 5'(D - k)) begin errors++; $display("FAIL drain_count_%0d got %0d want %0d", k, bus.count, D - k); end
    end
    checks++;
    if (bus.q_valid !== 1'b0) begin errors++; $display("FAIL empty_q_valid got %b want 0", bus.q_valid); end
    tick();
    checks++;
    if (bus.count !== 5'd0) begin errors++; $display("FAIL underflow_count got %0d want 0", bus.count); end
    bus.q_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q [15];
    for (int k = 0; k < 5; k++)  exp_q[k] = 8'(8'h21 + k);
    for (int k = 0; k < 10; k++) exp_q[5 + k] = 8'(8'h30 + k);
    bus.q_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.i = 8'(8'h21 + k); bus.i_valid = 1'b1;
      tick();
    end
    checks++;
    if (bus.count !== 5'd5) begin errors++; $display("FAIL b2b_preload got %0d want 5", bus.count); end
    bus.q_ready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      bus.i = 8'(8'h30 + j); bus.i_valid = 1'b1;
      #1;
      checks++;
      if (bus.q !== exp_q[j]) begin errors++; $display("FAIL b2b_q_%0d got %h want %h", j, bus.q, exp_q[j]); end
      tick();
      checks++;
      if (bus.count !== 5'd5) begin errors++; $display("FAIL b2b_count_%0d got %0d want 5", j, bus.count); end
    end
    bus.i_valid = 1'b0;
    for (int j = 10; j < 15; j++) begin
      checks++;
      if (bus.q_valid !== 1'b1 || bus.q !== exp_q[j]) begin
        errors++; $display("FAIL b2b_tail_%0d got valid=%b q=%h want 1/%h", j, bus.q_valid, bus.q, exp_q[j]);
      end
      tick();
    end
    bus.q_ready = 1'b0;
    checks++;
    if (bus.count !== 5'd0) begin errors++; $display("FAIL b2b_end_count got %0d want 0", bus.count); end
  endtask

  task automatic test_reset_mid();
    bus.q_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.i = 8'(8'h51 + k); bus.i_valid = 1'b1;
      tick();
    end
    checks++;
    if (bus.count !== 5'd3) begin errors++; $display("FAIL mid_pre_count got %0d want 3", bus.count); end
    rst = 1'b1; bus.i = 8'h60; bus.i_valid = 1'b1;
    #1;
    checks++;
    if (bus.i_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_i_ready got %b want 0", bus.i_ready); end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.count !== 5'd0 || bus.q_valid !== 1'b0 || bus.i_ready !== 1'b0) begin
      errors++; $display("FAIL mid_after_rst got count=%0d q_valid=%b i_ready=%b want 0/0/0",
                          bus.count, bus.q_valid, bus.i_ready);
    end
    tick();
    checks++;
    if (bus.count !== 5'd0 || bus.i_ready !== 1'b1) begin
      errors++; $display("FAIL mid_recover got count=%0d i_ready=%b want 0/1", bus.count, bus.i_ready);
    end
    bus.i = 8'h77; tick();
    bus.i = 8'h78; tick();
    bus.i_valid = 1'b0;
    checks++;
    if (bus.count !== 5'd2) begin errors++; $display("FAIL mid_push_count got %0d want 2", bus.count); end
    bus.q_ready = 1'b1;
    checks++;
    if (bus.q_valid !== 1'b1 || bus.q !== 8'h77) begin
      errors++; $display("FAIL mid_q0 got valid=%b q=%h want 1/77", bus.q_valid, bus.q);
    end
    tick();
    checks++;
    if (bus.q_valid !== 1'b1 || bus.q !== 8'h78) begin
      errors++; $display("FAIL mid_q1 got valid=%b q=%h want 1/78", bus.q_valid, bus.q);
    end
    tick();
    bus.q_ready = 1'b0;
    checks++;
    if (bus.q_valid !== 1'b0 || bus.count !== 5'd0) begin
      errors++; $display("FAIL mid_empty got valid=%b count=%0d want 0/0", bus.q_valid, bus.count);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
